// File: rtl/sdram_arb_pkg.sv
// Shared types and constants for the two-port SDRAM request arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package sdram_arb_pkg;

    // Arbiter sequencing: take a request, present it to the controller,
    // wait for completion, then pulse the response back to the owner.
    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ISSUE    = 2'd1,
        WAIT_ACK = 2'd2,
        RESP     = 2'd3
    } arb_state_e;

    // Default datapath width and the strobe width it implies.
    localparam int DATA_W_DFLT = 32;
    localparam int STRB_W      = DATA_W_DFLT / 8;

    // Single-beat transfers only: the controller length field never moves.
    localparam logic [7:0] CORE_LEN_SINGLE = 8'd0;

    // Byte-enable width for an arbitrary data width.
    function automatic int strb_width(input int data_w);
        return data_w / 8;
    endfunction

endpackage

// File: rtl/sdram_req_arbiter_if.sv
// Requester-side bundle: one request handshake plus a one-cycle response.
// Latency: n/a (signal bundle only).
// Backpressure: req_ready from the arbiter gates req_valid; responses cannot be stalled.
interface sdram_req_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    localparam int SW = DATA_W / 8;

    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic [SW-1:0]     req_wstrb;
    logic              resp_valid;
    logic [DATA_W-1:0] resp_rdata;
    logic              resp_err;

    // The requester drives the request and observes ready/response.
    modport master (
        output req_valid,
        output req_write,
        output req_addr,
        output req_wdata,
        output req_wstrb,
        input  req_ready,
        input  resp_valid,
        input  resp_rdata,
        input  resp_err
    );

    // The arbiter consumes the request and produces ready/response.
    modport slave (
        input  req_valid,
        input  req_write,
        input  req_addr,
        input  req_wdata,
        input  req_wstrb,
        output req_ready,
        output resp_valid,
        output resp_rdata,
        output resp_err
    );

endinterface

// File: rtl/sdram_rr_pick.sv
// Two-way request picker: round-robin against the last owner, or port 0 first when fixed.
// Latency: purely combinational.
// Backpressure: none; the caller decides whether the pick is consumed.
module sdram_rr_pick (
    input  logic [1:0] valid,
    input  logic       last,
    input  logic       fixed,
    output logic       grant_vld,
    output logic       grant_id
);

    // A lone requester always wins; a tie goes to the port that did not go last,
    // or to port 0 when priority is fixed.
    always_comb begin
        grant_vld = |valid;
        grant_id  = 1'b0;
        if (valid == 2'b11) begin
            grant_id = fixed ? 1'b0 : ~last;
        end else if (valid[1]) begin
            grant_id = 1'b1;
        end
    end

endmodule

// File: rtl/sdram_req_arbiter.sv
// Shares one SDRAM controller request port between two requesters, one transaction at a time.
// Latency: grant T, core request from T+1, response pulse the cycle after core_ack.
// Backpressure: only one requester is readied per idle cycle; core_accept stalls the issue phase.
module sdram_req_arbiter
    import sdram_arb_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int FIXED_PRIO = 0
) (
    input  logic                clock,
    input  logic                reset,

    sdram_req_arbiter_if.slave  m0,
    sdram_req_arbiter_if.slave  m1,

    output logic [DATA_W/8-1:0] core_wr,
    output logic                core_rd,
    output logic [7:0]          core_len,
    output logic [ADDR_W-1:0]   core_addr,
    output logic [DATA_W-1:0]   core_wdata,
    input  logic                core_accept,
    input  logic                core_ack,
    input  logic                core_error,
    input  logic [DATA_W-1:0]   core_rdata
);

    localparam int SW = strb_width(DATA_W);

    // Byte address to word address: the two low bits are cleared on capture.
    localparam logic [ADDR_W-1:0] WORD_MASK = {{(ADDR_W-2){1'b1}}, 2'b00};

    arb_state_e        state_q,   state_d;
    logic              owner_q,   owner_d;
    logic              write_q,   write_d;
    logic [ADDR_W-1:0] addr_q,    addr_d;
    logic [DATA_W-1:0] wdata_q,   wdata_d;
    logic [SW-1:0]     wstrb_q,   wstrb_d;
    logic [DATA_W-1:0] rdata_q,   rdata_d;
    logic              err_q,     err_d;
    logic              rr_last_q, rr_last_d;

    logic              grant_vld;
    logic              grant_id;

    logic              sel_write;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;
    logic [SW-1:0]     sel_wstrb;

    logic              rdy0, rdy1;
    logic              rsp0, rsp1;
    logic              null_write;

    sdram_rr_pick u_pick (
        .valid     ({m1.req_valid, m0.req_valid}),
        .last      (rr_last_q),
        .fixed     (FIXED_PRIO != 0),
        .grant_vld (grant_vld),
        .grant_id  (grant_id)
    );

    // Route the picked requester's fields toward the capture registers.
    always_comb begin
        sel_write = m0.req_write;
        sel_addr  = m0.req_addr;
        sel_wdata = m0.req_wdata;
        sel_wstrb = m0.req_wstrb;
        if (grant_id) begin
            sel_write = m1.req_write;
            sel_addr  = m1.req_addr;
            sel_wdata = m1.req_wdata;
            sel_wstrb = m1.req_wstrb;
        end
    end

    // A write with no enabled bytes is completed locally and never reaches the controller.
    assign null_write = write_q && (wstrb_q == '0);

    // Next-state and capture logic for the single outstanding transaction.
    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        write_d   = write_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        rdata_d   = rdata_q;
        err_d     = err_q;
        rr_last_d = rr_last_q;

        case (state_q)
            IDLE: begin
                if (grant_vld) begin
                    owner_d = grant_id;
                    write_d = sel_write;
                    addr_d  = sel_addr & WORD_MASK;
                    wdata_d = sel_wdata;
                    wstrb_d = sel_wstrb;
                    state_d = ISSUE;
                end
            end

            ISSUE: begin
                if (null_write) begin
                    rdata_d = '0;
                    err_d   = 1'b0;
                    state_d = RESP;
                end else if (core_accept) begin
                    if (core_ack) begin
                        // Controller finished in the same cycle it took the request.
                        rdata_d = write_q ? '0 : core_rdata;
                        err_d   = core_error;
                        state_d = RESP;
                    end else begin
                        state_d = WAIT_ACK;
                    end
                end
            end

            WAIT_ACK: begin
                if (core_ack) begin
                    rdata_d = write_q ? '0 : core_rdata;
                    err_d   = core_error;
                    state_d = RESP;
                end
            end

            RESP: begin
                rr_last_d = owner_q;
                state_d   = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and capture registers; reset abandons any transaction in flight.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= IDLE;
            owner_q   <= 1'b0;
            write_q   <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            rdata_q   <= '0;
            err_q     <= 1'b0;
            rr_last_q <= 1'b1;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            write_q   <= write_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
            rdata_q   <= rdata_d;
            err_q     <= err_d;
            rr_last_q <= rr_last_d;
        end
    end

    // Handshake, controller strobes and response pulses, all held quiet during reset.
    always_comb begin
        rdy0    = 1'b0;
        rdy1    = 1'b0;
        rsp0    = 1'b0;
        rsp1    = 1'b0;
        core_rd = 1'b0;
        core_wr = '0;
        if (!reset) begin
            if (state_q == IDLE && grant_vld) begin
                rdy0 = ~grant_id;
                rdy1 = grant_id;
            end
            if (state_q == ISSUE) begin
                core_rd = ~write_q;
                core_wr = write_q ? wstrb_q : '0;
            end
            if (state_q == RESP) begin
                rsp0 = ~owner_q;
                rsp1 = owner_q;
            end
        end
    end

    assign m0.req_ready  = rdy0;
    assign m1.req_ready  = rdy1;
    assign m0.resp_valid = rsp0;
    assign m1.resp_valid = rsp1;
    assign m0.resp_rdata = rsp0 ? rdata_q : '0;
    assign m1.resp_rdata = rsp1 ? rdata_q : '0;
    assign m0.resp_err   = rsp0 & err_q;
    assign m1.resp_err   = rsp1 & err_q;

    assign core_len   = CORE_LEN_SINGLE;
    assign core_addr  = addr_q;
    assign core_wdata = wdata_q;

endmodule

// File: doc/sdram_req_arbiter.md
Name: sdram_req_arbiter

Overview:
Two-port round-robin arbiter that shares one SDRAM controller request port (strobe-write, read, accept, ack) between two requesters, e.g. instruction fetch and load/store.
- Registers one requester's transaction, issues it to the controller, waits for the ack, then returns a one-cycle response to the owner.
- Exactly one transaction is outstanding at a time; no bursts (length field tied to 0).

Parameters:
ADDR_W, 32, request/core address width
DATA_W, 32, data width; strobe width is DATA_W/8
FIXED_PRIO, 0, 1 = port 0 always wins ties; 0 = round-robin

Ports:
clock  in  1  clock
reset  in  1  reset, synchronous, active-high
m0_req_valid  in  1  port 0 request present
m0_req_ready  out  1  port 0 request taken this cycle
m0_req_write  in  1  1 = write, 0 = read
m0_req_addr  in  ADDR_W  byte address
m0_req_wdata  in  DATA_W  write data
m0_req_wstrb  in  DATA_W/8  byte enables
m0_resp_valid  out  1  one-cycle response pulse
m0_resp_rdata  out  DATA_W  read data (valid with resp_valid)
m0_resp_err  out  1  error flag (valid with resp_valid)
m1_* : same ten signals for port 1
core_wr  out  DATA_W/8  write strobes to controller
core_rd  out  1  read request to controller
core_len  out  8  burst length, constant 0
core_addr  out  ADDR_W  word-aligned address
core_wdata  out  DATA_W  write data
core_accept  in  1  controller took request
core_ack  in  1  controller completed request
core_error  in  1  controller error, valid with ack
core_rdata  in  DATA_W  controller read data, valid with ack

Behaviour:
- States: IDLE, ISSUE, WAIT_ACK, RESP.
- Reset values: state=IDLE; all req_ready, resp_valid, resp_err, core_rd, core_wr = 0; resp_rdata = 0; core_addr/core_wdata = 0; rr_last = 1 (port 0 wins first).
- IDLE, grant:
  - Only valid port: it wins.
  - Both valid: port != rr_last wins; with FIXED_PRIO=1, port 0 wins.
  - Winner's req_ready is driven combinationally in this same cycle, so the request is taken the same cycle it is presented. The loser's req_ready stays 0.
  - On grant, capture addr (bits [1:0] forced to 0), wdata, write, wstrb and owner id. Go to ISSUE.
- Write with wstrb==0:
  - Captured, but no core access is made; go directly to RESP.
  - Response is err=0, rdata=0.
- ISSUE:
  - Drive core_rd = !write; core_wr = write ? wstrb : 0; address and data from the captured registers.
  - Stay until core_accept=1. Then go to WAIT_ACK, unless core_ack=1 in the same cycle, in which case capture the response and go to RESP.
  - Requests are held stable while not accepted.
- WAIT_ACK:
  - core_rd and core_wr = 0.
  - On core_ack=1: capture core_rdata (reads; writes capture 0) and core_error; go to RESP.
  - There is no timeout.
- RESP:
  - Owner's resp_valid=1 for exactly one cycle with the registered rdata/err; the other port's resp_valid=0.
  - Set rr_last = owner; go to IDLE.
- Latency:
  - Grant in cycle T, core request asserted from T+1.
  - Accept at T+1 and ack at cycle A gives resp_valid at A+1.
  - Next grant no earlier than the cycle after RESP.
- core_ack or core_accept outside ISSUE/WAIT_ACK is ignored. Neither changes state or produces a response.
- Reset mid-operation:
  - Any state returns to IDLE and no response pulse is produced.
  - Requesters must reissue.
- core_len is always 0.

Decomposition:
- Package sdram_arb_pkg holds:
  - the state enum typedef;
  - the constant STRB_W = DATA_W/8;
  - the constant CORE_LEN_SINGLE = 8'd0.
- Optional sub-module sdram_rr_pick: a 2-way round-robin picker with inputs valid[1:0], last and fixed, and output grant id. Everything else stays in the top.

Test Plan:
- Port 0 read, addr 0x0000_1006, core accepts at T+1, acks 3 cycles later with rdata 0xDEADBEEF:
  - core_addr = 0x0000_1004, core_rd = 1 for 1 cycle;
  - m0_resp_valid pulse with rdata 0xDEADBEEF, err = 0; m1 silent.
- Both ports valid in the same IDLE cycle, twice in a row (rr_last = 1 after reset):
  - first grant port 0, second grant port 1;
  - with FIXED_PRIO=1, both grants go to port 0.
- Port 1 write wdata 0x12345678, wstrb 0b0101, core_accept held low 4 cycles:
  - core_wr = 0b0101 stable for 5 cycles until accept;
  - m1_resp_valid after ack, err = core_error (drive 1, expect 1).
- Port 0 write with wstrb 0:
  - no core_rd/core_wr activity;
  - m0_resp_valid 2 cycles after grant, err = 0.
- Reset asserted in WAIT_ACK, then a late core_ack:
  - returns to IDLE with no resp_valid on either port;
  - the late ack is ignored;
  - the next request is granted normally.
- Accept and ack in the same ISSUE cycle:
  - goes directly to RESP, resp_valid the next cycle with the captured rdata.
